devil_campaign_sequencer: RTL and testbench

- Drives the control and delay registers of the snoop-response fault injector (devil_in_fpga) from a small on-chip table of test entries.
- Runs each entry in turn: arm, wait for the injector's end flag or a timeout, disarm, wait until the injector is back in IDLE with its end flag cleared, then apply an inter-test gap.
- Sits between the AXI-Lite register file and the injector. It replaces the manual, software-driven enable/disable handshake.

---
 rtl/devil_campaign_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_devil_campaign_sequencer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/devil_campaign_sequencer.sv
// Table-driven test campaign sequencer for the devil_in_fpga snoop-response fault injector.
// Arms each entry, waits for end or timeout, disarms cleanly, then applies an inter-test gap.
module devil_campaign_sequencer #(
    parameter int unsigned DEPTH              = 8,
    parameter int unsigned IDX_W              = 3,
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32
) (
    input  logic                          ace_aclk,
    input  logic                          ace_areset,
    input  logic                          i_start,
    input  logic                          i_abort,
    input  logic                          i_wr_en,
    input  logic [IDX_W-1:0]              i_wr_idx,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] i_wr_ctrl,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] i_wr_delay,
    input  logic [IDX_W:0]                i_num_entries,
    input  logic [15:0]                   i_gap_cycles,
    input  logic [31:0]                   i_timeout_cycles,
    input  logic                          i_devil_end,
    input  logic [3:0]                    i_devil_state,
    output logic [C_S_AXI_DATA_WIDTH-1:0] o_control_reg,
    output logic [C_S_AXI_DATA_WIDTH-1:0] o_delay_reg,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_aborted,
    output logic [IDX_W-1:0]              o_cur_idx,
    output logic [15:0]                   o_pass_cnt,
    output logic [15:0]                   o_timeout_cnt,
    output logic [2:0]                    o_seq_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_ARM      = 3'd2,
        S_WAIT_END = 3'd3,
        S_DISARM   = 3'd4,
        S_GAP      = 3'd5,
        S_NEXT     = 3'd6
    } seq_state_t;

    localparam logic [IDX_W:0] DEPTH_W = (IDX_W+1)'(DEPTH);
    localparam logic [C_S_AXI_DATA_WIDTH-1:0] ARM_BIT     = C_S_AXI_DATA_WIDTH'(32'h0000_0001);
    // arm, osh_end and end bits of the injector control word
    localparam logic [C_S_AXI_DATA_WIDTH-1:0] DISARM_MASK = C_S_AXI_DATA_WIDTH'(32'h0003_0001);

    seq_state_t state, next_state;

    logic [C_S_AXI_DATA_WIDTH-1:0] tbl_ctrl  [DEPTH];
    logic [C_S_AXI_DATA_WIDTH-1:0] tbl_delay [DEPTH];

    logic [IDX_W-1:0] idx;
    logic             abort_pend;
    logic [31:0]      to_cnt;
    logic [15:0]      gap_cnt;

    logic [IDX_W:0]   num_run;
    logic [IDX_W:0]   idx_plus1;
    logic             to_hit;
    logic             gap_done;
    logic             last_entry;
    logic             dev_quiet;
    logic             abort_exit;

    assign num_run    = (i_num_entries > DEPTH_W) ? DEPTH_W : i_num_entries;
    assign idx_plus1  = {1'b0, idx} + {{IDX_W{1'b0}}, 1'b1};
    assign last_entry = (idx_plus1 == num_run);
    assign to_hit     = (i_timeout_cycles != '0) && (to_cnt == (i_timeout_cycles - 32'd1));
    assign gap_done   = (({1'b0, gap_cnt} + 17'd1) >= {1'b0, i_gap_cycles});
    assign dev_quiet  = !i_devil_end && (i_devil_state == 4'd0);
    assign abort_exit = abort_pend || i_abort;

    always_ff @(posedge ace_aclk or posedge ace_areset) begin
        if (ace_areset) state <= S_IDLE;
        else            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:     if (i_start && (num_run != '0)) next_state = S_LOAD;
            S_LOAD:     next_state = i_abort ? S_DISARM : S_ARM;
            S_ARM:      next_state = i_abort ? S_DISARM : S_WAIT_END;
            S_WAIT_END: if (i_abort || i_devil_end || to_hit) next_state = S_DISARM;
            S_DISARM:   if (dev_quiet) next_state = abort_exit ? S_IDLE : S_GAP;
            S_GAP: begin
                if (i_abort)       next_state = S_IDLE;
                else if (gap_done) next_state = S_NEXT;
            end
            S_NEXT:     next_state = (i_abort || last_entry) ? S_IDLE : S_LOAD;
            default:    next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge ace_aclk or posedge ace_areset) begin
        if (ace_areset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tbl_ctrl[i]  <= '0;
                tbl_delay[i] <= '0;
            end
        end else if ((state == S_IDLE) && i_wr_en) begin
            tbl_ctrl[i_wr_idx]  <= i_wr_ctrl;
            tbl_delay[i_wr_idx] <= i_wr_delay;
        end
    end

    // Masking happens on the edge that enters DISARM so the injector never sees an armed word there.
    always_ff @(posedge ace_aclk or posedge ace_areset) begin
        if (ace_areset) begin
            o_control_reg <= '0;
            o_delay_reg   <= '0;
        end else if (next_state == S_IDLE) begin
            o_control_reg <= '0;
        end else if (state == S_LOAD) begin
            o_delay_reg   <= tbl_delay[idx];
            o_control_reg <= (next_state == S_DISARM) ? (tbl_ctrl[idx] & ~DISARM_MASK)
                                                      : (tbl_ctrl[idx] & ~ARM_BIT);
        end else if ((state == S_ARM) && (next_state == S_WAIT_END)) begin
            o_control_reg <= o_control_reg | ARM_BIT;
        end else if (next_state == S_DISARM) begin
            o_control_reg <= o_control_reg & ~DISARM_MASK;
        end
    end

    always_ff @(posedge ace_aclk or posedge ace_areset) begin
        if (ace_areset) begin
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_aborted     <= 1'b0;
            o_pass_cnt    <= '0;
            o_timeout_cnt <= '0;
            idx           <= '0;
            abort_pend    <= 1'b0;
            to_cnt        <= '0;
            gap_cnt       <= '0;
        end else begin
            gap_cnt <= (state == S_GAP) ? gap_cnt + 16'd1 : '0;

            if (state == S_ARM)
                to_cnt <= '0;
            else if ((state == S_WAIT_END) && (next_state == S_WAIT_END))
                to_cnt <= to_cnt + 32'd1;

            if ((state == S_WAIT_END) && !i_abort) begin
                if (i_devil_end) begin
                    if (o_pass_cnt != '1) o_pass_cnt <= o_pass_cnt + 16'd1;
                end else if (to_hit) begin
                    if (o_timeout_cnt != '1) o_timeout_cnt <= o_timeout_cnt + 16'd1;
                end
            end

            if (i_abort && ((state == S_LOAD) || (state == S_ARM) ||
                            (state == S_WAIT_END) || (state == S_DISARM)))
                abort_pend <= 1'b1;

            if ((state == S_NEXT) && (next_state == S_LOAD))
                idx <= idx_plus1[IDX_W-1:0];

            if (state == S_IDLE) begin
                if (i_start) begin
                    o_done        <= (num_run == '0);
                    o_busy        <= (num_run != '0);
                    o_aborted     <= 1'b0;
                    o_pass_cnt    <= '0;
                    o_timeout_cnt <= '0;
                    idx           <= '0;
                    abort_pend    <= 1'b0;
                end
            end else if (next_state == S_IDLE) begin
                o_busy     <= 1'b0;
                o_aborted  <= abort_exit;
                o_done     <= !abort_exit;
                abort_pend <= 1'b0;
            end
        end
    end

    assign o_cur_idx   = idx;
    assign o_seq_state = state;

endmodule

// File: tb/tb_devil_campaign_sequencer.sv
// Self-checking bench for devil_campaign_sequencer: behavioural injector, arm/disarm monitor,
// vector table, randomized campaigns against an outcome-level model, and corner-case sequences.
module tb_devil_campaign_sequencer;

    localparam int DEPTH = 8;
    localparam int IDX_W = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        i_start = 1'b0, i_abort = 1'b0, i_wr_en = 1'b0;
    logic [2:0]  i_wr_idx = '0;
    logic [31:0] i_wr_ctrl = '0, i_wr_delay = '0;
    logic [3:0]  i_num_entries = '0;
    logic [15:0] i_gap_cycles = '0;
    logic [31:0] i_timeout_cycles = '0;
    logic        dev_end = 1'b0;
    logic [3:0]  dev_state = '0;

    logic [31:0] o_control_reg, o_delay_reg;
    logic        o_busy, o_done, o_aborted;
    logic [2:0]  o_cur_idx, o_seq_state;
    logic [15:0] o_pass_cnt, o_timeout_cnt;

    devil_campaign_sequencer #(.DEPTH(DEPTH), .IDX_W(IDX_W), .C_S_AXI_DATA_WIDTH(32)) dut (
        .ace_aclk(clk), .ace_areset(rst),
        .i_start(i_start), .i_abort(i_abort),
        .i_wr_en(i_wr_en), .i_wr_idx(i_wr_idx), .i_wr_ctrl(i_wr_ctrl), .i_wr_delay(i_wr_delay),
        .i_num_entries(i_num_entries), .i_gap_cycles(i_gap_cycles), .i_timeout_cycles(i_timeout_cycles),
        .i_devil_end(dev_end), .i_devil_state(dev_state),
        .o_control_reg(o_control_reg), .o_delay_reg(o_delay_reg),
        .o_busy(o_busy), .o_done(o_done), .o_aborted(o_aborted), .o_cur_idx(o_cur_idx),
        .o_pass_cnt(o_pass_cnt), .o_timeout_cnt(o_timeout_cnt), .o_seq_state(o_seq_state)
    );

    int n_cmp = 0;
    int n_fail = 0;

    logic [31:0] tbl_ctrl  [DEPTH];
    logic [31:0] tbl_delay [DEPTH];
    int          inj_delay [DEPTH];
    int          inj_hold = 1;
    int          arm_cnt = 0, wait_cyc = 0, gap_cyc = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Injector: raises end cur_d cycles after arm; after disarm drops state, then end two cycles later.
    int ph = 0, icnt = 0, cur_d = 0;
    always @(posedge clk) begin
        #1;
        if (rst) begin
            ph = 0; icnt = 0; dev_end = 1'b0; dev_state = 4'd0;
        end else begin
            case (ph)
                0: if (o_control_reg[0]) begin
                    ph = 1; icnt = 0; dev_state = 4'd3;
                    cur_d = inj_delay[o_cur_idx];
                    if (cur_d == 0) dev_end = 1'b1;
                end
                1: if (!o_control_reg[0]) begin
                    ph = 2; icnt = 0;
                end else begin
                    icnt++;
                    if (cur_d > 0 && icnt == cur_d) dev_end = 1'b1;
                end
                default: begin
                    icnt++;
                    if (icnt >= inj_hold) dev_state = 4'd0;
                    if (icnt >= inj_hold + 2) begin dev_end = 1'b0; ph = 0; end
                end
            endcase
        end
    end

    logic        prev_b0 = 1'b0;
    logic        clean = 1'b1;
    logic [31:0] armed_ctrl = '0;
    always @(negedge clk) begin
        if (!rst) begin
            if (o_control_reg[0] && !prev_b0) begin
                chk("rearm_clean", clean, 1);
                chk("arm_idx", o_cur_idx, arm_cnt);
                chk("arm_ctrl", o_control_reg, tbl_ctrl[o_cur_idx] | 32'd1);
                chk("arm_delay", o_delay_reg, tbl_delay[o_cur_idx]);
                armed_ctrl = tbl_ctrl[o_cur_idx] | 32'd1;
                arm_cnt++;
                clean = 1'b0;
            end else if (!o_control_reg[0] && prev_b0) begin
                chk("disarm_state", o_seq_state, 4);
                chk("disarm_ctrl", o_control_reg, armed_ctrl & ~32'h0003_0001);
            end
            if (!o_control_reg[0] && !dev_end && dev_state == 4'd0) clean = 1'b1;
            if (o_seq_state == 3'd3) wait_cyc++;
            if (o_seq_state == 3'd5) gap_cyc++;
        end
        prev_b0 = o_control_reg[0];
    end

    task automatic wr(input int idx, input logic [31:0] c, input logic [31:0] d);
        i_wr_en = 1'b1; i_wr_idx = 3'(idx); i_wr_ctrl = c; i_wr_delay = d;
        @(negedge clk);
        i_wr_en = 1'b0;
        tbl_ctrl[idx] = c; tbl_delay[idx] = d;
    endtask

    task automatic start_run(input int n, input int g, input int t);
        i_num_entries = 4'(n); i_gap_cycles = 16'(g); i_timeout_cycles = 32'(t);
        arm_cnt = 0; wait_cyc = 0; gap_cyc = 0;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (o_busy && k < budget) begin @(negedge clk); k++; end
        if (o_busy) begin
            chk("busy_bound", o_busy, 0);
            rst = 1'b1; @(negedge clk); @(negedge clk); rst = 1'b0;
        end
    endtask

    task automatic check_end(input int ep, input int et, input int ea, input int ew, input int eg);
        chk("end_done", o_done, 1);
        chk("end_aborted", o_aborted, 0);
        chk("end_busy", o_busy, 0);
        chk("end_ctrl", o_control_reg, 0);
        chk("end_state", o_seq_state, 0);
        chk("pass_cnt", o_pass_cnt, ep);
        chk("timeout_cnt", o_timeout_cnt, et);
        chk("arm_count", arm_cnt, ea);
        chk("wait_cycles", wait_cyc, ew);
        chk("gap_cycles", gap_cyc, eg);
    endtask

    // Outcome model: each entry passes if end arrives before the timeout window closes.
    task automatic model(input int n, input int g, input int t,
                         output int ep, output int et, output int ea, output int ew, output int eg);
        ea = (n > DEPTH) ? DEPTH : n;
        ep = 0; et = 0; ew = 0;
        for (int i = 0; i < ea; i++) begin
            if (inj_delay[i] >= 0 && (t == 0 || inj_delay[i] < t)) begin
                ep++; ew += inj_delay[i] + 1;
            end else begin
                et++; ew += t;
            end
        end
        eg = ea * ((g == 0) ? 1 : g);
    endtask

    typedef struct {
        int n, gap, to, dly, hold;
        int e_pass, e_to, e_arms, e_wait, e_gap;
    } vec_t;

    vec_t vt[6];

    initial begin
        int ep, et, ea, ew, eg, k;
        vt[0] = '{2, 4, 0, 10, 1,  2, 0, 2, 22, 8};
        vt[1] = '{1, 0, 20, -1, 3, 0, 1, 1, 20, 1};
        vt[2] = '{15, 1, 0, 3, 0,  8, 0, 8, 32, 8};
        vt[3] = '{3, 2, 6, 5, 1,   3, 0, 3, 18, 6};
        vt[4] = '{3, 2, 5, 5, 2,   0, 3, 3, 15, 6};
        vt[5] = '{2, 3, 0, 2, 50,  2, 0, 2, 6, 6};

        for (int i = 0; i < DEPTH; i++) begin
            tbl_ctrl[i] = '0; tbl_delay[i] = '0; inj_delay[i] = 1;
        end

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ctrl", o_control_reg, 0);
        chk("rst_delay", o_delay_reg, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_aborted", o_aborted, 0);
        chk("rst_idx", o_cur_idx, 0);
        chk("rst_pass", o_pass_cnt, 0);
        chk("rst_timeout", o_timeout_cnt, 0);
        chk("rst_state", o_seq_state, 0);
        rst = 1'b0;
        @(negedge clk);

        wr(0, 32'h0002_0203, 32'd100);
        wr(1, 32'h0001_0003, 32'd101);
        for (int i = 2; i < DEPTH; i++) wr(i, $urandom, 32'd100 + 32'(i));

        foreach (vt[v]) begin
            for (int i = 0; i < DEPTH; i++) inj_delay[i] = vt[v].dly;
            inj_hold = vt[v].hold;
            start_run(vt[v].n, vt[v].gap, vt[v].to);
            wait_idle(4000);
            check_end(vt[v].e_pass, vt[v].e_to, vt[v].e_arms, vt[v].e_wait, vt[v].e_gap);
        end

        for (int r = 0; r < 8; r++) begin
            int n, g, t;
            for (int i = 0; i < DEPTH; i++) wr(i, $urandom, $urandom);
            n = $urandom_range(0, 15);
            g = $urandom_range(0, 5);
            t = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(3, 30);
            for (int i = 0; i < DEPTH; i++)
                inj_delay[i] = (t != 0 && $urandom_range(0, 4) == 0) ? -1 : $urandom_range(0, 25);
            inj_hold = $urandom_range(0, 8);
            model(n, g, t, ep, et, ea, ew, eg);
            start_run(n, g, t);
            wait_idle(4000);
            check_end(ep, et, ea, ew, eg);
        end

        // Abort five cycles into WAIT_END with an injector that never ends.
        for (int i = 0; i < DEPTH; i++) inj_delay[i] = -1;
        inj_hold = 3;
        start_run(2, 2, 0);
        k = 0;
        while (o_seq_state != 3'd3 && k < 50) begin @(negedge clk); k++; end
        chk("abort_reach_wait", o_seq_state, 3);
        repeat (5) @(negedge clk);
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        chk("abort_disarm", o_seq_state, 4);
        wait_idle(500);
        chk("abort_aborted", o_aborted, 1);
        chk("abort_done", o_done, 0);
        chk("abort_pass", o_pass_cnt, 0);
        chk("abort_timeout", o_timeout_cnt, 0);
        chk("abort_ctrl", o_control_reg, 0);
        chk("abort_state", o_seq_state, 0);

        // Zero entries: done the cycle after start, nothing armed.
        start_run(0, 0, 0);
        chk("zero_done", o_done, 1);
        chk("zero_busy", o_busy, 0);
        chk("zero_aborted", o_aborted, 0);
        chk("zero_ctrl", o_control_reg, 0);
        chk("zero_state", o_seq_state, 0);

        // Table write and restart attempt while busy must both be ignored.
        for (int i = 0; i < DEPTH; i++) inj_delay[i] = 4;
        inj_hold = 2;
        start_run(8, 1, 0);
        repeat (10) @(negedge clk);
        i_wr_en = 1'b1; i_wr_idx = 3'd5; i_wr_ctrl = 32'hDEAD_BEEF; i_wr_delay = 32'h0000_1234;
        i_start = 1'b1;
        @(negedge clk);
        i_wr_en = 1'b0; i_start = 1'b0;
        wait_idle(4000);
        check_end(8, 0, 8, 40, 8);
        start_run(8, 1, 0);
        wait_idle(4000);
        check_end(8, 0, 8, 40, 8);

        // Asynchronous reset mid-campaign, then confirm the table was cleared.
        for (int i = 0; i < DEPTH; i++) inj_delay[i] = 8;
        inj_hold = 1;
        start_run(2, 1, 0);
        k = 0;
        while (o_seq_state != 3'd3 && k < 50) begin @(negedge clk); k++; end
        #3 rst = 1'b1;
        #1;
        chk("arst_ctrl", o_control_reg, 0);
        chk("arst_busy", o_busy, 0);
        chk("arst_state", o_seq_state, 0);
        chk("arst_idx", o_cur_idx, 0);
        chk("arst_delay", o_delay_reg, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin tbl_ctrl[i] = '0; tbl_delay[i] = '0; end
        inj_delay[0] = 1;
        start_run(1, 0, 0);
        wait_idle(500);
        check_end(1, 0, 1, 2, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit: actual expired required finish");
        $fatal(1);
    end

endmodule
